// File: rtl/cgra_rr_port_arbiter_if.sv
// Link bundle between the competing router inputs, the port arbiter and the downstream output.
// The slave modport is the arbiter view; the master modport is the environment view.
interface cgra_rr_port_arbiter_if #(
   parameter int unsigned NUM_REQ    = 5,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned STALL_W    = 16
);
   localparam int unsigned SrcW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_dest_x;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_dest_y;
   logic [NUM_REQ-1:0]            req_multicast;
   logic                          out_valid;
   logic                          out_ready;
   logic [DATA_WIDTH-1:0]         out_data;
   logic [ADDR_WIDTH-1:0]         out_dest_x;
   logic [ADDR_WIDTH-1:0]         out_dest_y;
   logic                          out_multicast;
   logic [SrcW-1:0]               out_src;
   logic [STALL_W-1:0]            stall_cnt;

   modport slave (
      input  req_valid, req_data, req_dest_x, req_dest_y, req_multicast, out_ready,
      output req_ready, out_valid, out_data, out_dest_x, out_dest_y, out_multicast, out_src,
             stall_cnt
   );

   modport master (
      output req_valid, req_data, req_dest_x, req_dest_y, req_multicast, out_ready,
      input  req_ready, out_valid, out_data, out_dest_x, out_dest_y, out_multicast, out_src,
             stall_cnt
   );
endinterface

// File: rtl/cgra_rr_port_arbiter.sv
// Round-robin arbiter plus registered output stage for one mesh router output port.
// Losing requesters are simply not granted, so no flit is ever dropped.
module cgra_rr_port_arbiter #(
   parameter int unsigned NUM_REQ    = 5,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned STALL_W    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   cgra_rr_port_arbiter_if.slave bus
);
   localparam int unsigned SrcW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic [ADDR_WIDTH-1:0] out_dest_x_q, out_dest_x_d;
   logic [ADDR_WIDTH-1:0] out_dest_y_q, out_dest_y_d;
   logic                  out_multicast_q, out_multicast_d;
   logic [SrcW-1:0]       out_src_q, out_src_d;
   logic [SrcW-1:0]       rr_ptr_q, rr_ptr_d;
   logic [STALL_W-1:0]    stall_cnt_q, stall_cnt_d;

   logic                  can_load;
   logic                  grant_vld;
   logic [SrcW-1:0]       grant_idx;
   logic [NUM_REQ-1:0]    ready;

   assign can_load = !out_valid_q || bus.out_ready;

   // Scan the search order backwards so the requester closest to rr_ptr is assigned last and wins.
   always_comb begin
      int idx;
      idx       = 0;
      grant_vld = 1'b0;
      grant_idx = '0;
      for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= int'(NUM_REQ)) idx = idx - int'(NUM_REQ);
         if (bus.req_valid[idx]) begin
            grant_vld = 1'b1;
            grant_idx = SrcW'(idx);
         end
      end
      grant_vld = grant_vld && can_load && !rst;
   end

   always_comb begin
      ready = '0;
      if (grant_vld) ready[grant_idx] = 1'b1;
   end

   always_comb begin
      out_valid_d     = out_valid_q;
      out_data_d      = out_data_q;
      out_dest_x_d    = out_dest_x_q;
      out_dest_y_d    = out_dest_y_q;
      out_multicast_d = out_multicast_q;
      out_src_d       = out_src_q;
      rr_ptr_d        = rr_ptr_q;
      stall_cnt_d     = stall_cnt_q;
      if (grant_vld) begin
         out_valid_d     = 1'b1;
         out_data_d      = bus.req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
         out_dest_x_d    = bus.req_dest_x[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
         out_dest_y_d    = bus.req_dest_y[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
         out_multicast_d = bus.req_multicast[grant_idx];
         out_src_d       = grant_idx;
         rr_ptr_d        = (grant_idx == SrcW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end else if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end
      if (out_valid_q && !bus.out_ready && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q     <= 1'b0;
         out_data_q      <= '0;
         out_dest_x_q    <= '0;
         out_dest_y_q    <= '0;
         out_multicast_q <= 1'b0;
         out_src_q       <= '0;
         rr_ptr_q        <= '0;
         stall_cnt_q     <= '0;
      end else begin
         out_valid_q     <= out_valid_d;
         out_data_q      <= out_data_d;
         out_dest_x_q    <= out_dest_x_d;
         out_dest_y_q    <= out_dest_y_d;
         out_multicast_q <= out_multicast_d;
         out_src_q       <= out_src_d;
         rr_ptr_q        <= rr_ptr_d;
         stall_cnt_q     <= stall_cnt_d;
      end
   end

   assign bus.req_ready     = ready;
   assign bus.out_valid     = out_valid_q;
   assign bus.out_data      = out_data_q;
   assign bus.out_dest_x    = out_dest_x_q;
   assign bus.out_dest_y    = out_dest_y_q;
   assign bus.out_multicast = out_multicast_q;
   assign bus.out_src       = out_src_q;
   assign bus.stall_cnt     = stall_cnt_q;
endmodule

// File: tb/tb_cgra_rr_port_arbiter.sv
// Directed bench for cgra_rr_port_arbiter: reset, single grant, fairness, wrap/skip,
// backpressure with stall counting, and reset while stalled.
module tb_cgra_rr_port_arbiter;
   localparam int unsigned N  = 5;
   localparam int unsigned DW = 16;
   localparam int unsigned AW = 4;
   localparam int unsigned SW = 16;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   cgra_rr_port_arbiter_if #(
      .NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STALL_W(SW)
   ) bus ();

   cgra_rr_port_arbiter #(
      .NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STALL_W(SW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [DW-1:0] d, input logic [AW-1:0] x,
                          input logic [AW-1:0] y, input logic mc);
      bus.req_data[i*DW +: DW]   = d;
      bus.req_dest_x[i*AW +: AW] = x;
      bus.req_dest_y[i*AW +: AW] = y;
      bus.req_multicast[i]       = mc;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst    = 1'b1;
      bus.req_valid     = '1;
      bus.req_data      = '0;
      bus.req_dest_x    = '0;
      bus.req_dest_y    = '0;
      bus.req_multicast = '0;
      bus.out_ready     = 1'b0;
      for (int i = 0; i < int'(N); i++) set_req(i, 16'hA000 + 16'(i), 4'(i), 4'(15 - i), 1'b0);

      // T1 reset with every requester asking
      #1;
      chk("t1_ready_in_rst", 32'(bus.req_ready), 32'h0);
      step();
      step();
      chk("t1_ready_in_rst2", 32'(bus.req_ready), 32'h0);
      chk("t1_out_valid", 32'(bus.out_valid), 32'h0);
      chk("t1_stall_cnt", 32'(bus.stall_cnt), 32'h0);
      chk("t1_out_src", 32'(bus.out_src), 32'h0);
      rst = 1'b0;
      bus.req_valid = '0;

      // T2 single request from requester 2
      set_req(2, 16'h1234, 4'd3, 4'd1, 1'b1);
      bus.req_valid = 5'b00100;
      bus.out_ready = 1'b1;
      #1;
      chk("t2_ready", 32'(bus.req_ready), 32'h04);
      step();
      bus.req_valid = '0;
      chk("t2_out_valid", 32'(bus.out_valid), 32'h1);
      chk("t2_out_data", 32'(bus.out_data), 32'h1234);
      chk("t2_out_dest_x", 32'(bus.out_dest_x), 32'h3);
      chk("t2_out_dest_y", 32'(bus.out_dest_y), 32'h1);
      chk("t2_out_src", 32'(bus.out_src), 32'h2);
      chk("t2_out_mcast", 32'(bus.out_multicast), 32'h1);

      // T4 wrap/skip: pointer is 3, only req 0 and 1 ask
      bus.req_valid = 5'b00011;
      #1;
      chk("t4_ready0", 32'(bus.req_ready), 32'h01);
      step();
      chk("t4_src0", 32'(bus.out_src), 32'h0);
      bus.req_valid = 5'b00010;
      #1;
      chk("t4_ready1", 32'(bus.req_ready), 32'h02);
      step();
      chk("t4_src1", 32'(bus.out_src), 32'h1);
      chk("t4_data1", 32'(bus.out_data), 32'hA001);
      bus.req_valid = '0;
      step();
      chk("t4_drain_valid", 32'(bus.out_valid), 32'h0);
      chk("t4_drain_hold", 32'(bus.out_data), 32'hA001);

      // T3 fairness: bring pointer to 0 via req 4, then all five ask continuously
      bus.req_valid = 5'b10000;
      step();
      chk("t3_pre_src4", 32'(bus.out_src), 32'h4);
      bus.req_valid = '1;
      for (int k = 0; k < 7; k++) begin
         step();
         chk($sformatf("t3_src_%0d", k), 32'(bus.out_src), 32'(k % 5));
         chk($sformatf("t3_valid_%0d", k), 32'(bus.out_valid), 32'h1);
      end
      bus.req_valid = '0;

      // T5 backpressure: flit from req 1 (0xA001) is held for 10 cycles
      set_req(1, 16'hBEEF, 4'd7, 4'd9, 1'b0);
      bus.req_valid = 5'b00010;
      bus.out_ready = 1'b0;
      for (int k = 0; k < 10; k++) begin
         #1;
         chk($sformatf("t5_ready_%0d", k), 32'(bus.req_ready), 32'h0);
         step();
         chk($sformatf("t5_hold_%0d", k), 32'(bus.out_data), 32'hA001);
      end
      chk("t5_stall_cnt", 32'(bus.stall_cnt), 32'd10);
      bus.out_ready = 1'b1;
      #1;
      chk("t5_ready_release", 32'(bus.req_ready), 32'h02);
      step();
      chk("t5_new_valid", 32'(bus.out_valid), 32'h1);
      chk("t5_new_data", 32'(bus.out_data), 32'hBEEF);
      chk("t5_new_dest_x", 32'(bus.out_dest_x), 32'h7);
      chk("t5_stall_after", 32'(bus.stall_cnt), 32'd10);

      // T6 reset while stalled
      bus.req_valid = '0;
      bus.out_ready = 1'b0;
      step();
      chk("t6_stall_11", 32'(bus.stall_cnt), 32'd11);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t6_out_valid", 32'(bus.out_valid), 32'h0);
      chk("t6_stall_cnt", 32'(bus.stall_cnt), 32'h0);
      chk("t6_out_data", 32'(bus.out_data), 32'h0);
      bus.req_valid = '1;
      bus.out_ready = 1'b1;
      #1;
      chk("t6_ready_from0", 32'(bus.req_ready), 32'h01);
      step();
      chk("t6_src0", 32'(bus.out_src), 32'h0);
      chk("t6_data0", 32'(bus.out_data), 32'hA000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
